// File: rtl/proof_scoreboard.sv
// proof_scoreboard: latency-aligned DUT vs golden compare with warm-up skip, counters and first-fail capture.
// Define PROOF_ASSERT_EN to add an immediate equality assertion on every live compare.
module proof_scoreboard #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 1,
    parameter int SKIP    = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH:0]   gold_out,
    input  logic [WIDTH:0]   dut_out,
    input  logic             clear,
    output logic             check_valid,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH:0]   first_exp,
    output logic [WIDTH:0]   first_got,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {WARMUP = 2'd0, CHECK = 2'd1, FAIL = 2'd2} state_t;

    state_t         r_state, w_state_nxt;
    logic [3:0]     r_skip;
    logic           r_vld  [1:LATENCY];
    logic [WIDTH:0] r_gold [1:LATENCY];
    logic           w_cmp, w_eq;

    assign state = r_state;
    assign w_cmp = r_vld[LATENCY] && (r_state != WARMUP);

    // An unknown compare result falls through to "not equal", so X/Z on dut_out is a mismatch.
    always_comb begin
        w_eq = 1'b0;
        if (dut_out == r_gold[LATENCY]) w_eq = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == WARMUP) w_state_nxt = (r_skip == 4'(SKIP)) ? CHECK : WARMUP;
        else if (clear) w_state_nxt = CHECK;
        else if (w_cmp && !w_eq) w_state_nxt = FAIL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WARMUP;
            r_skip  <= 4'd0;
            for (int k = 1; k <= LATENCY; k++) begin
                r_vld[k]  <= 1'b0;
                r_gold[k] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_skip    <= (r_state == WARMUP) ? r_skip + 4'd1 : r_skip;
            r_vld[1]  <= in_valid;
            r_gold[1] <= gold_out;
            for (int k = 2; k <= LATENCY; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_gold[k] <= r_gold[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            check_valid <= 1'b0;
            mismatch    <= 1'b0;
            err_sticky  <= 1'b0;
            match_count <= '0;
            err_count   <= '0;
            first_exp   <= '0;
            first_got   <= '0;
        end else begin
            check_valid <= w_cmp && !clear;
            mismatch    <= w_cmp && !clear && !w_eq;
            if (clear) begin
                err_sticky  <= 1'b0;
                match_count <= '0;
                err_count   <= '0;
                first_exp   <= '0;
                first_got   <= '0;
            end else if (w_cmp && w_eq) begin
                if (!(&match_count)) match_count <= match_count + CNT_W'(1);
            end else if (w_cmp) begin
                if (!(&err_count)) err_count <= err_count + CNT_W'(1);
                err_sticky <= 1'b1;
                // Captures only load on the transition into FAIL, so they hold the first failing pair.
                if (r_state == CHECK) begin
                    first_exp <= r_gold[LATENCY];
                    first_got <= dut_out;
                end
            end
        end
    end

`ifdef PROOF_ASSERT_EN
    always @(posedge clk) begin
        if (rst && w_cmp) assert (dut_out == r_gold[LATENCY]);
    end
`else
`endif
endmodule
